// File: rtl/serial_add_feeder.sv
// serial_add_feeder: drives a 1-bit serial adder cell LSB-first and collects
// its sum bits into a parallel result. Block logic runs on posedge cp; the
// cell evaluates on negedge cp, so every bit makes one round trip per cycle.
//
// Handshake: start acts as a request with an implicit ready equal to
// "state is IDLE". A start seen while RUN or DONE is dropped, not queued,
// and a/b are only sampled on the posedge where start is accepted.
module serial_add_feeder #(
  parameter int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             cp,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ny,
  input  logic             z,
  output logic             x1,
  output logic             x2,
  output logic             y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  // Only the not-yet-presented operand bits are kept; bit 0 goes straight
  // into x1/x2 when an operation is accepted.
  logic [WIDTH-2:0] a_sh_q, a_sh_d;
  logic [WIDTH-2:0] b_sh_q, b_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             x1_q, x1_d;
  logic             x2_q, x2_d;
  logic             y_q, y_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cout_q, cout_d;

  // Next-state and datapath updates for each state.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    x1_d    = x1_q;
    x2_d    = x2_q;
    y_d     = y_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    cout_d  = cout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a[WIDTH-1:1];
          b_sh_d  = b[WIDTH-1:1];
          x1_d    = a[0];
          x2_d    = b[0];
          y_d     = 1'b0;
          sum_d   = '0;
          cout_d  = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // The cell has just evaluated the bit presented last cycle.
        sum_d  = {z, sum_q[WIDTH-1:1]};
        y_d    = ny;
        x1_d   = a_sh_q[0];
        x2_d   = b_sh_q[0];
        a_sh_d = a_sh_q >> 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          cout_d  = ny;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation silently.
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      x1_q    <= 1'b0;
      x2_q    <= 1'b0;
      y_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      x1_q    <= x1_d;
      x2_q    <= x2_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cout_q  <= cout_d;
    end
  end

  assign x1        = x1_q;
  assign x2        = x2_q;
  assign y         = y_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_add_feeder.sv
// Bench for serial_add_feeder together with a behavioural 1-bit serial adder
// cell. A cycle-age model derives busy/done/x1/x2/y/sum/cout from plain
// arithmetic on the accepted operands; directed tests pin literal results.
module tb_serial_add_feeder;
  localparam int WIDTH = 8;
  localparam int IDLE_AGE = 1000;

  // ---------------- clock / reset ----------------
  logic             cp = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             ny = 1'b0;
  logic             z = 1'b0;
  logic             x1, x2, y, busy, done, cout;
  logic [WIDTH-1:0] sum;
  logic [1:0]       dbg_state;

  always #5 cp = ~cp;

  serial_add_feeder #(.WIDTH(WIDTH)) dut (
    .cp(cp), .rst_n(rst_n), .start(start), .a(a), .b(b), .ny(ny), .z(z),
    .x1(x1), .x2(x2), .y(y), .busy(busy), .done(done), .sum(sum),
    .cout(cout), .dbg_state(dbg_state)
  );

  // 1-bit serial adder cell, evaluated on the falling edge.
  always @(negedge cp) begin
    z  <= x1 ^ x2 ^ y;
    ny <= (x1 & x2) | (x1 & y) | (x2 & y);
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Carry into bit j of aa+bb, from plain addition of the low j bits.
  function automatic logic carry_into(input logic [WIDTH-1:0] aa, input logic [WIDTH-1:0] bb,
                                      input int j);
    longint unsigned m, s;
    m = (64'd1 << j) - 64'd1;
    s = (longint'(aa) & m) + (longint'(bb) & m);
    return s[j];
  endfunction

  // ---------------- model + compare process ----------------
  int               age = IDLE_AGE;   // posedges since the accepted start
  logic [WIDTH-1:0] m_a = '0;
  logic [WIDTH-1:0] m_b = '0;
  logic [WIDTH:0]   m_res = '0;       // result expected to be held
  logic [WIDTH:0]   exp_q[$];

  always begin
    @(posedge cp);
    if (!rst_n) begin
      age   = IDLE_AGE;
      m_res = '0;
      exp_q.delete();
    end else begin
      if (age > WIDTH && start) begin
        age = 0;
        m_a = a;
        m_b = b;
        exp_q.push_back({1'b0, a} + {1'b0, b});
      end else if (age < IDLE_AGE) begin
        age++;
      end
      if (age == WIDTH) begin
        if (exp_q.size() > 0) m_res = exp_q.pop_front();
      end
    end
    #1;
    check("busy", 32'(busy), 32'(age < WIDTH));
    check("done", 32'(done), 32'(age == WIDTH));
    if (done) done_cnt++;
    if (age < WIDTH) begin
      check("x1", 32'(x1), 32'(m_a[age]));
      check("x2", 32'(x2), 32'(m_b[age]));
      check("y_run", 32'(y), 32'(carry_into(m_a, m_b, age)));
      check("cout_run", 32'(cout), 32'h0);
    end else begin
      check("sum_held", 32'(sum), 32'(m_res[WIDTH-1:0]));
      check("cout_held", 32'(cout), 32'(m_res[WIDTH]));
      check("y_held", 32'(y), 32'(m_res[WIDTH]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_start(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb);
    @(negedge cp);
    start = 1'b1;
    a = va;
    b = vb;
    @(negedge cp);
    start = 1'b0;
    a = WIDTH'($urandom_range(0, 255));
    b = WIDTH'($urandom_range(0, 255));
  endtask

  // Called on the negedge right after the accepting posedge. Returns the
  // number of cycles to done, busy-high samples and y-high samples taken
  // after the first capture.
  task automatic wait_done(output int lat, output int busy_n, output int y_n);
    lat = 0;
    busy_n = 0;
    y_n = 0;
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      if (busy) busy_n++;
      @(negedge cp);
      lat++;
      if (y) y_n++;
    end
    if (!done) check("done_timeout", 32'h0, 32'h1);
  endtask

  // ---------------- directed tests ----------------
  int lat, bn, yn, d0;
  int done_k[$];

  initial begin
    repeat (2) @(negedge cp);
    #1;
    check("rst_sum", 32'(sum), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    @(negedge cp);
    rst_n = 1'b1;
    repeat (2) @(negedge cp);

    // 0x5A + 0x3C
    do_start(8'h5A, 8'h3C);
    wait_done(lat, bn, yn);
    check("t1_latency", 32'(lat), 32'd8);
    check("t1_busy_cycles", 32'(bn), 32'd8);
    check("t1_sum", 32'(sum), 32'h96);
    check("t1_cout", 32'(cout), 32'h0);
    repeat (2) @(negedge cp);

    // 0xFF + 0x01: carry high from first capture through last
    do_start(8'hFF, 8'h01);
    wait_done(lat, bn, yn);
    check("t2_y_high", 32'(yn), 32'd8);
    check("t2_sum", 32'(sum), 32'h00);
    check("t2_cout", 32'(cout), 32'h1);
    repeat (2) @(negedge cp);

    // 0xFF + 0xFF with an ignored start in the middle
    d0 = done_cnt;
    do_start(8'hFF, 8'hFF);
    repeat (2) @(negedge cp);
    start = 1'b1; a = 8'h00; b = 8'h00;
    @(negedge cp);
    start = 1'b0;
    wait_done(lat, bn, yn);
    check("t3_sum", 32'(sum), 32'hFE);
    check("t3_cout", 32'(cout), 32'h1);
    repeat (6) @(negedge cp);
    check("t3_done_pulses", 32'(done_cnt - d0), 32'd1);

    // reset mid-operation, then 0x12 + 0x34
    d0 = done_cnt;
    do_start(8'h81, 8'h7F);
    repeat (3) @(negedge cp);
    rst_n = 1'b0;
    #1;
    check("t4_rst_busy", 32'(busy), 32'h0);
    check("t4_rst_x", 32'({x1, x2, y, done, cout}), 32'h0);
    check("t4_rst_sum", 32'(sum), 32'h0);
    repeat (2) @(negedge cp);
    rst_n = 1'b1;
    repeat (12) @(negedge cp);
    check("t4_no_done", 32'(done_cnt - d0), 32'd0);
    do_start(8'h12, 8'h34);
    wait_done(lat, bn, yn);
    check("t4_sum", 32'(sum), 32'h46);
    check("t4_cout", 32'(cout), 32'h0);
    repeat (2) @(negedge cp);

    // start held high: accepts at posedge 0 and posedge 10
    @(negedge cp);
    start = 1'b1; a = 8'h0F; b = 8'hF1;
    for (int k = 0; k < 20; k++) begin
      @(negedge cp);
      if (done) begin
        done_k.push_back(k);
        check("t5_sum", 32'(sum), 32'h00);
        check("t5_cout", 32'(cout), 32'h1);
      end
    end
    start = 1'b0;
    check("t5_pulse_count", 32'(done_k.size()), 32'd2);
    if (done_k.size() == 2) begin
      check("t5_done0_at", 32'(done_k[0]), 32'd8);
      check("t5_done1_at", 32'(done_k[1]), 32'd18);
    end
    repeat (4) @(negedge cp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
